// File: rtl/regfile_seqran_param.sv
// +----------------------------------------------------------------------------+
// | regfile_seqran_param : append-only parameter store, seq + random read port |
// +----------------------------------------------------------------------------+
`default_nettype none

module regfile_seqran_param #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  we,
  input  logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   wr_cnt,
  output logic                  ovf,
  input  logic                  seq_re,
  input  logic                  seq_rewind,
  input  logic                  ran_re,
  input  logic [ADDR_WIDTH-1:0] ran_r_addr,
  output logic                  r_valid,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_err,
  output logic                  seq_done
);

  localparam int                IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] CNT_DEPTH = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH + 1)'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH:0]   rd_ptr;

  logic write_ok;
  logic ran_hit;
  logic seq_take;
  logic seq_hit;

  assign full     = (wr_cnt == CNT_DEPTH);
  assign seq_done = (rd_ptr == wr_cnt);
  assign write_ok = we && !full;
  // Validity uses the pre-write count, so a same-cycle write is never forwarded.
  assign ran_hit  = ({1'b0, ran_r_addr} < wr_cnt);
  assign seq_take = seq_re && !ran_re && !seq_rewind;
  assign seq_hit  = (rd_ptr < wr_cnt);

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (!clr && write_ok) begin
      mem[wr_cnt[IDX_W-1:0]] <= w_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_data  <= '0;
    end else if (clr) begin
      wr_cnt  <= '0;
      rd_ptr  <= '0;
      ovf     <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_valid <= ran_re || seq_take;

      if (ran_re) begin
        r_addr <= ran_r_addr;
        r_err  <= !ran_hit;
        r_data <= ran_hit ? mem[ran_r_addr[IDX_W-1:0]] : '0;
      end else if (seq_take) begin
        r_addr <= rd_ptr[ADDR_WIDTH-1:0];
        r_err  <= !seq_hit;
        r_data <= seq_hit ? mem[rd_ptr[IDX_W-1:0]] : '0;
      end

      if (seq_rewind) begin
        rd_ptr <= '0;
      end else if (seq_take && seq_hit) begin
        rd_ptr <= rd_ptr + CNT_ONE;
      end

      if (we) begin
        if (full) begin
          ovf <= 1'b1;
        end else begin
          wr_cnt <= wr_cnt + CNT_ONE;
        end
      end
    end
  end

endmodule

`default_nettype wire
